// File: rtl/xctcmsg_pkg.sv
// Shared types for the xctcmsg writeback path.
package xctcmsg_pkg;

    localparam int unsigned VALUE_W   = 64;
    localparam int unsigned RD_W      = 5;
    localparam int unsigned ROB_TAG_W = 8;
    localparam int unsigned DROP_W    = 16;

    // Metadata carried alongside an execute-stage result
    typedef struct packed {
        logic [RD_W-1:0]      rd;
        logic                 rd_we;
        logic [ROB_TAG_W-1:0] rob_tag;
    } exe_stage_passthrough_t;

    // One buffered writeback result
    typedef struct packed {
        logic [VALUE_W-1:0]     value;
        exe_stage_passthrough_t passthrough;
    } writeback_buffer_entry_t;

endpackage

// File: rtl/xctcmsg_wb_buffer.sv
// Small FIFO decoupling the xctcmsg writeback arbiter from the core WB stage.
// Flush kills all entries and counts them; reset clears without counting.
module xctcmsg_wb_buffer
    import xctcmsg_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [63:0]                  in_value,
    input  exe_stage_passthrough_t       in_passthrough,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_value,
    output exe_stage_passthrough_t       out_passthrough,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    writeback_buffer_entry_t mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occupancy_q, occupancy_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic [DROP_W:0]   drop_sum;
    logic              push;
    logic              pop;

    // Handshakes depend only on registered state, flush and reset
    always_comb begin
        in_ready  = (occupancy_q != OCC_W'(DEPTH)) && !flush && !rst;
        out_valid = (occupancy_q != OCC_W'(0)) && !flush && !rst;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state for pointers, occupancy and the saturating drop counter
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occupancy_d  = occupancy_q;
        drop_count_d = drop_count_q;
        drop_sum     = (DROP_W+1)'(drop_count_q) + (DROP_W+1)'(occupancy_q);
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            occupancy_d  = '0;
            drop_count_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy_d = occupancy_q + OCC_W'(1);
                2'b01:   occupancy_d = occupancy_q - OCC_W'(1);
                default: occupancy_d = occupancy_q;
            endcase
        end
    end

    // Control state register; reset wins over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occupancy_q  <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occupancy_q  <= occupancy_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Entry storage; contents of invalid slots are don't-care
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{value: in_value, passthrough: in_passthrough};
        end
    end

    // Head entry straight from storage, no bypass
    always_comb begin
        out_value       = mem_q[rd_ptr_q].value;
        out_passthrough = mem_q[rd_ptr_q].passthrough;
        occupancy       = occupancy_q;
        drop_count      = drop_count_q;
    end

endmodule
